// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: sums two WIDTH-bit operands CHUNK bits per clock,
// carrying between chunks through a single register, with start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one chunk summed per cycle, LSB chunk first
// DONE    | result valid, done pulse; start here chains the next operation
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] res_next;
    logic             load;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        count_d     = count_q;
        res_d       = res_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        out_d       = out_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
        // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at the LSBs.
        res_next = (res_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                c_d     = csum[CHUNK];
                res_d   = res_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(NCHUNK - 1)) begin
                    out_d       = res_next;
                    carry_out_d = csum[CHUNK];
                    overflow_d  = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Subtraction is a + ~b + 1; sign bits are kept since a and b shift away.
        if (load) begin
            a_d     = in1;
            b_d     = sub ? ~in2 : in2;
            c_d     = sub | carry_in;
            a_msb_d = in1[WIDTH-1];
            b_msb_d = sub ? ~in2[WIDTH-1] : in2[WIDTH-1];
            count_d = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            count_q     <= '0;
            res_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            out_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            count_q     <= count_d;
            res_q       <= res_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            out_q       <= out_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign out       = out_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: WIDTH=8 with CHUNK=1,2,4,8 plus WIDTH=1, all sharing
// the same stimulus, checked against an integer-arithmetic reference model.
module tb_serial_chunk_adder;

    logic       clk = 1'b0;
    logic       reset, start, sub, carry_in;
    logic [7:0] in1, in2;

    logic       busy_v [5];
    logic       done_v [5];
    logic       co_v   [5];
    logic       ov_v   [5];
    logic [7:0] out_v  [4];
    logic [0:0] out_w1;

    int errors = 0;
    int checks = 0;

    int         lat_r [5];
    int         nb_r  [5];
    logic [7:0] out_r [5];
    logic       co_r  [5];
    logic       ov_r  [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_chunk_adder #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
            .clk(clk), .reset(reset), .start(start), .sub(sub),
            .in1(in1), .in2(in2), .carry_in(carry_in),
            .busy(busy_v[g]), .done(done_v[g]), .out(out_v[g]),
            .carry_out(co_v[g]), .overflow(ov_v[g])
        );
    end

    serial_chunk_adder #(.WIDTH(1), .CHUNK(1)) u_w1 (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .in1(in1[0:0]), .in2(in2[0:0]), .carry_in(carry_in),
        .busy(busy_v[4]), .done(done_v[4]), .out(out_w1),
        .carry_out(co_v[4]), .overflow(ov_v[4])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unsigned result/carry from plain sums; overflow from the signed range.
    function automatic void ref_op(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic s, input logic ci,
                                   output logic [7:0] r, output logic co, output logic ov);
        longint m    = longint'(1) << w;
        longint half = m / 2;
        longint ua   = longint'(a) % m;
        longint ub   = longint'(b) % m;
        longint sa   = (ua >= half) ? ua - m : ua;
        longint sb   = (ub >= half) ? ub - m : ub;
        longint tot, sr;
        if (s) begin
            tot = ua - ub + m;
            sr  = sa - sb;
        end else begin
            tot = ua + ub + longint'(ci);
            sr  = sa + sb + longint'(ci);
        end
        co = (tot >= m);
        r  = 8'(tot % m);
        ov = (sr > half - 1) || (sr < -half);
    endfunction

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci);
        @(negedge clk);
        in1 = a; in2 = b; sub = s; carry_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start on all instances, then watch 10 cycles recording latency and result.
    task automatic run_all(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci);
        for (int g = 0; g < 5; g++) begin
            lat_r[g] = 0; nb_r[g] = 0; out_r[g] = '0; co_r[g] = 1'b0; ov_r[g] = 1'b0;
        end
        start_op(a, b, s, ci);
        for (int k = 1; k <= 10; k++) begin
            for (int g = 0; g < 5; g++) begin
                if (busy_v[g]) nb_r[g]++;
                if (done_v[g] && lat_r[g] == 0) begin
                    lat_r[g] = k;
                    out_r[g] = (g == 4) ? {7'b0, out_w1} : out_v[g];
                    co_r[g]  = co_v[g];
                    ov_r[g]  = ov_v[g];
                end
            end
            if (k < 10) @(negedge clk);
        end
    endtask

    task automatic wait_done1(input int k0, output int lat);
        lat = k0;
        while (!done_v[1] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       s, ci;
        logic [7:0] r;
        logic       co, ov;
    } vec_t;

    vec_t dir_tab[5] = '{
        '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0},
        '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1}
    };

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         lat, npulse;
        logic [7:0] ra, rb, er;
        logic       rs, rci, eco, eov;

        reset = 1'b1; start = 1'b0; sub = 1'b0; carry_in = 1'b0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_v[1]), 0);
        chk("rst_done", 32'(done_v[1]), 0);
        chk("rst_out", 32'(out_v[1]), 0);
        chk("rst_co", 32'(co_v[1]), 0);
        chk("rst_ov", 32'(ov_v[1]), 0);
        reset = 1'b0;

        foreach (dir_tab[i]) begin
            run_all(dir_tab[i].a, dir_tab[i].b, dir_tab[i].s, dir_tab[i].ci);
            chk($sformatf("dir%0d_lat", i), 32'(lat_r[1]), 5);
            chk($sformatf("dir%0d_busy", i), 32'(nb_r[1]), 4);
            chk($sformatf("dir%0d_out", i), 32'(out_r[1]), 32'(dir_tab[i].r));
            chk($sformatf("dir%0d_co", i), 32'(co_r[1]), 32'(dir_tab[i].co));
            chk($sformatf("dir%0d_ov", i), 32'(ov_r[1]), 32'(dir_tab[i].ov));
        end

        // Start during busy is dropped; start in DONE chains directly.
        start_op(8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        in1 = 8'h10; in2 = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done1(3, lat);
        chk("hs_ignored_done", 32'(done_v[1]), 1);
        chk("hs_ignored_out", 32'(out_v[1]), 32'h03);
        in1 = 8'h10; in2 = 8'h20; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hs_chain_busy", 32'(busy_v[1]), 1);
        chk("hs_hold_out1", 32'(out_v[1]), 32'h03);
        @(negedge clk);
        chk("hs_hold_out2", 32'(out_v[1]), 32'h03);
        wait_done1(2, lat);
        chk("hs_chain_lat", 32'(lat), 5);
        chk("hs_chain_out", 32'(out_v[1]), 32'h30);
        @(negedge clk);
        chk("hs_idle_done", 32'(done_v[1]), 0);
        chk("hs_idle_busy", 32'(busy_v[1]), 0);
        repeat (8) @(negedge clk);

        // Reset in the second busy cycle aborts without a done pulse.
        start_op(8'h33, 8'h44, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstrun_busy", 32'(busy_v[1]), 0);
        chk("rstrun_done", 32'(done_v[1]), 0);
        chk("rstrun_out", 32'(out_v[1]), 0);
        npulse = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[1]) npulse++;
        end
        chk("rstrun_nodone", 32'(npulse), 0);
        run_all(8'h01, 8'h01, 1'b0, 1'b0);
        chk("rstrun_after_out", 32'(out_r[1]), 32'h02);

        // WIDTH=1 exhaustive carry/overflow.
        for (int v = 0; v < 8; v++) begin
            ra = {7'b0, v[0]}; rb = {7'b0, v[1]}; rci = v[2];
            run_all(ra, rb, 1'b0, rci);
            ref_op(1, ra, rb, 1'b0, rci, er, eco, eov);
            chk($sformatf("w1_%0d_lat", v), 32'(lat_r[4]), 2);
            chk($sformatf("w1_%0d_out", v), 32'(out_r[4]), 32'(er));
            chk($sformatf("w1_%0d_co", v), 32'(co_r[4]), 32'(eco));
            chk($sformatf("w1_%0d_ov", v), 32'(ov_r[4]), 32'(eov));
        end

        // Random sweep over all CHUNK sizes at once.
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom); rci = 1'($urandom);
            run_all(ra, rb, rs, rci);
            ref_op(8, ra, rb, rs, rci, er, eco, eov);
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("rnd%0d_c%0d_lat", n, 1 << g), 32'(lat_r[g]), 32'((8 >> g) + 1));
                chk($sformatf("rnd%0d_c%0d_busy", n, 1 << g), 32'(nb_r[g]), 32'(8 >> g));
                chk($sformatf("rnd%0d_c%0d_out", n, 1 << g), 32'(out_r[g]), 32'(er));
                chk($sformatf("rnd%0d_c%0d_co", n, 1 << g), 32'(co_r[g]), 32'(eco));
                chk($sformatf("rnd%0d_c%0d_ov", n, 1 << g), 32'(ov_r[g]), 32'(eov));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
